// File: rtl/sweep_counter_ctrl.sv
// rtl/sweep_counter_ctrl.sv - sweep sequencer owning the W-bit up/down count register
// Optional SWEEP_DWELL_EN: hold one extra cycle at every non-final sweep endpoint.
module sweep_counter_ctrl #(
  parameter int W     = 4,
  parameter int LOOPW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [W-1:0]     lo,
  input  logic [W-1:0]     hi,
  input  logic [LOOPW-1:0] loops,
  output logic [W-1:0]     count,
  output logic             up_down,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LOOPW-1:0] loop_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] M_UP   = 2'd0;
  localparam logic [1:0] M_DOWN = 2'd1;
  localparam logic [1:0] M_RSVD = 2'd3;

`ifdef SWEEP_DWELL_EN
  localparam bit DWELL = 1'b1;
`else
  localparam bit DWELL = 1'b0;
`endif

  state_t           state, state_n;
  logic [1:0]       mode_q, mode_n;
  logic [W-1:0]     lo_q, lo_n, hi_q, hi_n;
  logic [LOOPW-1:0] loops_q, loops_n;
  logic [W-1:0]     count_n;
  logic             up_down_n, done_n, err_n;
  logic [LOOPW-1:0] loop_cnt_n;
  // lo_pend: TRI reached lo on the down leg with sweeps remaining; loop_cnt bumps on leaving it
  logic             lo_pend, lo_pend_n;
  logic             dwell_q, dwell_n;
  logic             last;
  logic [LOOPW-1:0] lc_inc;
  logic [W-1:0]     cnt_up, cnt_dn;

  assign busy = (state == RUN);

  always_comb begin
    state_n    = state;
    mode_n     = mode_q;
    lo_n       = lo_q;
    hi_n       = hi_q;
    loops_n    = loops_q;
    count_n    = count;
    up_down_n  = up_down;
    loop_cnt_n = loop_cnt;
    lo_pend_n  = lo_pend;
    dwell_n    = dwell_q;
    done_n     = 1'b0;
    err_n      = 1'b0;
    lc_inc     = LOOPW'(loop_cnt + 1'b1);
    last       = (loops_q != '0) && (lc_inc == loops_q);
    cnt_up     = W'(count + 1'b1);
    cnt_dn     = W'(count - 1'b1);

    case (state)
      IDLE: begin
        if (!stop && start) begin
          if ((lo >= hi) || (mode == M_RSVD)) begin
            err_n = 1'b1;
          end else begin
            state_n    = RUN;
            mode_n     = mode;
            lo_n       = lo;
            hi_n       = hi;
            loops_n    = loops;
            loop_cnt_n = '0;
            lo_pend_n  = 1'b0;
            dwell_n    = 1'b0;
            count_n    = (mode == M_DOWN) ? hi : lo;
            up_down_n  = (mode != M_DOWN);
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else begin
          case (mode_q)
            M_UP: begin
              if (count == hi_q) begin
                if (last) begin
                  state_n    = IDLE;
                  done_n     = 1'b1;
                  loop_cnt_n = lc_inc;
                end else if (DWELL && !dwell_q) begin
                  dwell_n = 1'b1;
                end else begin
                  dwell_n    = 1'b0;
                  loop_cnt_n = lc_inc;
                  count_n    = lo_q;
                end
              end else begin
                count_n = cnt_up;
              end
            end
            M_DOWN: begin
              if (count == lo_q) begin
                if (last) begin
                  state_n    = IDLE;
                  done_n     = 1'b1;
                  loop_cnt_n = lc_inc;
                end else if (DWELL && !dwell_q) begin
                  dwell_n = 1'b1;
                end else begin
                  dwell_n    = 1'b0;
                  loop_cnt_n = lc_inc;
                  count_n    = hi_q;
                end
              end else begin
                count_n = cnt_dn;
              end
            end
            default: begin
              if (up_down) begin
                if (lo_pend && DWELL && !dwell_q) begin
                  dwell_n = 1'b1;
                end else begin
                  if (lo_pend) loop_cnt_n = lc_inc;
                  lo_pend_n = 1'b0;
                  dwell_n   = 1'b0;
                  count_n   = cnt_up;
                  if (cnt_up == hi_q) up_down_n = 1'b0;
                end
              end else if (count == lo_q) begin
                // down leg parked at lo with up_down still 0 means this was the last sweep
                state_n    = IDLE;
                done_n     = 1'b1;
                loop_cnt_n = lc_inc;
              end else if ((count == hi_q) && DWELL && !dwell_q) begin
                dwell_n = 1'b1;
              end else begin
                dwell_n = 1'b0;
                count_n = cnt_dn;
                if ((cnt_dn == lo_q) && !last) begin
                  up_down_n = 1'b1;
                  lo_pend_n = 1'b1;
                end
              end
            end
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      loops_q  <= '0;
      count    <= '0;
      up_down  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      loop_cnt <= '0;
      lo_pend  <= 1'b0;
      dwell_q  <= 1'b0;
    end else begin
      state    <= state_n;
      mode_q   <= mode_n;
      lo_q     <= lo_n;
      hi_q     <= hi_n;
      loops_q  <= loops_n;
      count    <= count_n;
      up_down  <= up_down_n;
      done     <= done_n;
      err      <= err_n;
      loop_cnt <= loop_cnt_n;
      lo_pend  <= lo_pend_n;
      dwell_q  <= dwell_n;
    end
  end

endmodule

// File: doc/sweep_counter_ctrl.md
Name: sweep_counter_ctrl

Overview:
- Sequencing controller for the team's W-bit up/down counter.
- Owns the count register and drives the direction and sweep schedule.
- Sweeps between programmable bounds lo..hi in one of three modes (up-wrap, down-wrap, triangle), for a programmed number of sweeps or forever.
- Reports busy/done/err to the host sequencer, and exposes the direction and the count.

Parameters:
W, 4, counter width in bits
LOOPW, 8, width of sweep-count fields

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE
stop  input  1  abort a run
mode  input  2  0=UP, 1=DOWN, 2=TRI, 3=reserved
lo  input  W  lower bound
hi  input  W  upper bound
loops  input  LOOPW  sweeps to run; 0 = run until stop
count  output  W  current counter value
up_down  output  1  1=counting up, 0=counting down
busy  output  1  run in progress
done  output  1  one-cycle pulse on normal completion
err  output  1  one-cycle pulse on rejected start
loop_cnt  output  LOOPW  completed sweeps in current/last run

Behaviour:
- Reset (async, rst_n=0): count=0, up_down=0, busy=0, done=0, err=0, loop_cnt=0, state IDLE. Takes effect mid-run; the run is lost.
- States: IDLE, RUN. All outputs are registered.
- Start in IDLE, latched config:
  - start=1 latches mode, lo, hi and loops.
  - Reject if lo>=hi or mode=3: err=1 for one cycle, state stays IDLE, count unchanged.
  - Accept: next edge sets busy=1, loop_cnt=0, and loads the count.
    - UP/TRI: count=lo, up_down=1.
    - DOWN: count=hi, up_down=0.
- start while busy is ignored. Inputs lo/hi/mode/loops are ignored after latch.
- UP run:
  - count+1 each cycle.
  - On the edge after count==hi: loop_cnt+1. Then either finish, or count=lo if sweeps remain.
- DOWN run: mirror of UP; decrement; endpoint is lo; wrap reloads hi.
- TRI run:
  - One sweep is lo→hi→lo.
  - up_down updates on the same edge count reaches an endpoint: becomes 0 when count becomes hi. When count becomes lo, it becomes 1 only if sweeps remain, otherwise it stays 0.
  - loop_cnt+1 on the edge after count==lo is reached on the down leg.
- Finish (loops≠0 and loop_cnt reaches loops):
  - Same edge: state=IDLE, busy=0, done=1 for one cycle.
  - count holds its final endpoint; up_down holds.
- loops=0: run forever. loop_cnt wraps modulo 2^LOOPW; done never pulses.
- stop=1 in RUN: next edge state=IDLE, busy=0, count/up_down/loop_cnt hold, no done.
  - stop beats a simultaneous final-endpoint completion: no done.
  - stop and start together in IDLE: stop wins, start ignored, no err.
- Arithmetic: count never leaves [lo,hi] during a run. There is no modulo-2^W overflow because lo<hi is enforced.
- Latency: count moves one step per clock; start→first value is 1 cycle.

Optional Feature:
SWEEP_DWELL_EN
- Defined: count holds one extra cycle at every endpoint except the final one of a run (UP/DOWN before wrap; TRI at hi and at intermediate lo).
  - loop_cnt increments after the dwell cycle.
  - up_down changes on the first endpoint cycle, as in the non-dwell case.
  - stop during dwell behaves as in RUN.
- Undefined: no dwell; behaviour exactly as above.

Test Plan:
- Reset mid-run: lo=2, hi=5, mode=UP, loops=0, pulse rst_n low at count=4 -> immediately count=0, busy=0, up_down=0, loop_cnt=0.
- UP run: lo=2, hi=5, mode=UP, loops=2, start -> count 2,3,4,5,2,3,4,5; loop_cnt 1 on second 2. Next edge: busy=0, done=1 (one cycle), count=5, loop_cnt=2.
- TRI run: lo=1, hi=3, mode=TRI, loops=1 -> count 1,2,3,2,1 with up_down 1,1,0,0,0; then done=1, busy=0, loop_cnt=1.
- DOWN + stop: lo=0, hi=15, mode=DOWN, loops=0 -> count 15,14,…,0,15 (wrap); stop at count=7 -> busy=0, count holds 7, no done. start and stop together while IDLE -> no run, no err.
- Rejects: start with lo=6, hi=6 -> err one cycle, busy stays 0. Start with mode=3 -> err. start while busy -> ignored, run continues.
- SWEEP_DWELL_EN build: lo=1, hi=3, TRI, loops=2 -> 1,2,3,3,2,1,1,2,3,3,2,1, then done. Non-dwell build: 1,2,3,2,1,2,3,2,1, then done.
